universal_shift_reg: RTL

- Parametrised successor to the 4-bit serial-in/parallel-out register.
- Generalised to WIDTH bits, with four modes: hold, shift right, shift left and parallel load.
- Serial outputs on both ends.
- A word-assembly tracker emits a one-cycle strobe whenever WIDTH consecutive same-direction shifts have completed a fresh word.
- Used as the generic serial/parallel converter in datapath and I/O blocks.

---
 rtl/shift_pkg.sv | 15 +
 rtl/word_tracker.sv | 66 ++++++
 rtl/universal_shift_reg.sv | 59 +++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register.
//   MODE_*  : operation select driven on the mode port
//   DIR_*   : state encoding of the word-assembly direction tracker
package shift_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [1:0] DIR_IDLE  = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;

endpackage

// File: rtl/word_tracker.sv
// Word-assembly tracker: counts consecutive same-direction shifts and emits
// a one-cycle strobe when WIDTH of them have completed a fresh word.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   en           : clock enable (state holds when low)
//   mode         : operation select shared with the data register
//   shift_cnt    : shifts accumulated toward the current word
//   word_valid   : registered one-cycle word-completion strobe
module word_tracker
   import shift_pkg::*;
#(
   parameter int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             word_valid
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0] dir_state;
   logic [1:0] shift_dir;
   logic       is_shift;

   always_comb begin
      is_shift  = (mode == MODE_SHR) || (mode == MODE_SHL);
      shift_dir = (mode == MODE_SHR) ? DIR_RIGHT : DIR_LEFT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dir_state  <= DIR_IDLE;
         shift_cnt  <= '0;
         word_valid <= 1'b0;
      end else begin
         // Strobe defaults low; only a completing shift raises it.
         word_valid <= 1'b0;
         if (en) begin
            if (mode == MODE_LOAD) begin
               dir_state <= DIR_IDLE;
               shift_cnt <= '0;
            end else if (is_shift) begin
               if (dir_state == shift_dir) begin
                  if (shift_cnt == CNT_LAST) begin
                     // Word complete: keep direction, restart counting.
                     shift_cnt  <= '0;
                     word_valid <= 1'b1;
                  end else begin
                     shift_cnt <= shift_cnt + 1'b1;
                  end
               end else begin
                  // New direction (or first shift): partial word discarded,
                  // this shift is the first bit of the new word.
                  dir_state <= shift_dir;
                  shift_cnt <= CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with serial outputs on both ends and a word-completion strobe.
// Ports:
//   clk, rst         : clock and synchronous active-high reset
//   en               : clock enable
//   mode             : 00 hold, 01 shift right, 10 shift left, 11 load
//   sin_r, sin_l     : serial inputs for right / left shifts
//   pdata            : parallel load data
//   q                : registered contents
//   sout_r, sout_l   : q[0] and q[WIDTH-1]
//   word_valid       : one-cycle strobe when a fresh word is complete
//   shift_cnt        : shifts accumulated toward the current word
module universal_shift_reg
   import shift_pkg::*;
#(
   parameter int             WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int            CNT_W     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pdata,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             word_valid,
   output logic [CNT_W-1:0] shift_cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VAL;
      end else if (en) begin
         case (mode)
            MODE_SHR:  q <= {sin_r, q[WIDTH-1:1]};
            MODE_SHL:  q <= {q[WIDTH-2:0], sin_l};
            MODE_LOAD: q <= pdata;
            default:   q <= q;
         endcase
      end
   end

   assign sout_r = q[0];
   assign sout_l = q[WIDTH-1];

   word_tracker #(.WIDTH(WIDTH)) u_tracker (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mode       (mode),
      .shift_cnt  (shift_cnt),
      .word_valid (word_valid)
   );

endmodule
